// File: rtl/sum_bcd_emitter.sv
`default_nettype none
// ============================================================================
//  Module      : sum_bcd_emitter
//  Description : Captures a binary result, converts it to BCD by double dabble
//                and streams the decimal digits MSD first over valid/ready.
//                Optional leading-zero suppression: define SUM_BCD_LZS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module sum_bcd_emitter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic             CLK,
    input  logic             Init,
    input  logic             Start,
    input  logic [WIDTH-1:0] Value,
    output logic [3:0]       Digit,
    output logic             DigitValid,
    input  logic             DigitReady,
    output logic             DigitLast,
    output logic             IsEnd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);
    localparam logic [IW-1:0] c_idx_top  = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bcd;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [BW-1:0]    w_bcd_adj;
    logic [BW-1:0]    w_bcd_next;
    logic [IW-1:0]    w_idx_start;

    // Add-3 correction on every nibble before the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dd
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          (r_bcd[4*gi +: 4] + 4'd3) :
                                           r_bcd[4*gi +: 4];
        end
    endgenerate

    assign w_bcd_next = BW'({w_bcd_adj, r_shift[WIDTH-1]});

`ifdef SUM_BCD_LZS_EN
    // Start at the highest nonzero digit of the final BCD word; zero emits one digit.
    always_comb begin
        w_idx_start = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_bcd_next[4*i +: 4] != 4'd0) begin
                w_idx_start = IW'(i);
            end
        end
    end
`else
    assign w_idx_start = c_idx_top;
`endif

    always_ff @(posedge CLK) begin
        if (Init) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        DigitValid   = 1'b0;
        DigitLast    = 1'b0;
        IsEnd        = 1'b0;
        Digit        = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                DigitValid = 1'b1;
                DigitLast  = (r_idx == '0);
                for (int i = 0; i < DIGITS; i++) begin
                    if (r_idx == IW'(i)) begin
                        Digit = r_bcd[4*i +: 4];
                    end
                end
                if (DigitReady && (r_idx == '0)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                IsEnd = 1'b1;
                if (!Start) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Init) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_shift <= Value;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_CONV: begin
                    r_shift <= r_shift << 1;
                    r_bcd   <= w_bcd_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == c_cnt_last) begin
                        r_idx <= w_idx_start;
                    end
                end
                S_EMIT: begin
                    if (DigitReady && (r_idx != '0)) begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sum_bcd_emitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_bcd_emitter
//  Description : Self-checking bench; a queue-based decimal model predicts the
//                outputs every cycle. Define SUM_BCD_LZS_EN to match the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sum_bcd_emitter;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    typedef int iq_t[$];

    logic             CLK = 1'b0;
    logic             Init;
    logic             Start;
    logic [WIDTH-1:0] Value;
    logic [3:0]       Digit;
    logic             DigitValid;
    logic             DigitReady;
    logic             DigitLast;
    logic             IsEnd;

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;
    iq_t log_q;

    // model: 0 idle, 1 converting, 2 emitting, 3 finished
    int  m_mode = 0;
    int  m_wait = 0;
    iq_t m_q;

    iq_t e1, e2, e3, e5, e6;

    sum_bcd_emitter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .CLK        (CLK),
        .Init       (Init),
        .Start      (Start),
        .Value      (Value),
        .Digit      (Digit),
        .DigitValid (DigitValid),
        .DigitReady (DigitReady),
        .DigitLast  (DigitLast),
        .IsEnd      (IsEnd)
    );

    always #5 CLK = ~CLK;

    function automatic iq_t digits_of(input longint unsigned v);
        iq_t r;
        longint unsigned x = v;
`ifdef SUM_BCD_LZS_EN
        do begin
            r.push_front(int'(x % 10));
            x = x / 10;
        end while (x != 0);
`else
        for (int i = 0; i < DIGITS; i++) begin
            r.push_front(int'(x % 10));
            x = x / 10;
        end
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_seq(input string name, input iq_t act, input iq_t exp);
        bit ok = (act.size() == exp.size());
        if (ok) begin
            for (int i = 0; i < act.size(); i++) begin
                if (act[i] != exp[i]) ok = 1'b0;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %p expected %p", name, act, exp);
        end
    endtask

    // Compare process: outputs are stable at negedge; inputs seen here are
    // exactly those the next posedge samples, so the model advances here too.
    always @(negedge CLK) begin
        logic       ev, el, ee;
        logic [3:0] ed, ad;
        if (chk_en) begin
            ev = (m_mode == 2);
            el = ev && (m_q.size() == 1);
            ee = (m_mode == 3);
            ed = ev ? 4'(m_q[0]) : 4'd0;
            ad = ev ? Digit : 4'd0;
            check("outputs{valid,last,end,digit}",
                  {57'd0, DigitValid, DigitLast, IsEnd, ad},
                  {57'd0, ev, el, ee, ed});
            if (DigitValid && DigitReady) log_q.push_back(int'(Digit));
        end
        if (Init) begin
            m_mode = 0;
            m_q.delete();
        end else begin
            case (m_mode)
                0: if (Start) begin
                       m_q    = digits_of(longint'(Value));
                       m_wait = WIDTH;
                       m_mode = 1;
                   end
                1: begin
                       m_wait--;
                       if (m_wait == 0) m_mode = 2;
                   end
                2: if (DigitReady) begin
                       void'(m_q.pop_front());
                       if (m_q.size() == 0) m_mode = 3;
                   end
                default: if (!Start) m_mode = 0;
            endcase
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    // mode 0: ready always high; mode 1: random ready with a 5-cycle stall on the 4th digit
    task automatic run_txn(input logic [31:0] v, input int mode, input bit pulse, input bit hold);
        int n = 0;
        int stall = 0;
        log_q.delete();
        Value      = v;
        Start      = 1'b1;
        DigitReady = (mode == 0);
        cyc();
        if (pulse) Start = 1'b0;
        Value = $urandom;
        while (!IsEnd && n < 400) begin
            if (mode == 1) begin
                if (log_q.size() == 3 && stall < 5) begin
                    DigitReady = 1'b0;
                    stall++;
                end else begin
                    DigitReady = 1'($urandom_range(0, 1));
                end
            end
            cyc();
            n++;
        end
        check("end_reached", {63'd0, IsEnd}, 64'd1);
        DigitReady = 1'b0;
        if (hold) begin
            Start = 1'b1;
            repeat (10) cyc();
        end
        Start = 1'b0;
        cyc();
    endtask

    initial begin
        int n;
        logic [31:0] rv;
        Init = 1'b1; Start = 1'b0; Value = '0; DigitReady = 1'b0;
        e3 = '{4, 2, 9, 4, 9, 6, 7, 2, 9, 5};
`ifdef SUM_BCD_LZS_EN
        e1 = '{2, 3, 3, 1, 6, 8};
        e2 = '{0};
        e5 = '{4, 3, 2, 1};
        e6 = '{1, 0, 0, 0};
`else
        e1 = '{0, 0, 0, 0, 2, 3, 3, 1, 6, 8};
        e2 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e5 = '{0, 0, 0, 0, 0, 0, 4, 3, 2, 1};
        e6 = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
`endif
        repeat (2) cyc();
        chk_en = 1'b1;
        check("reset_state", {57'd0, Digit, DigitValid, DigitLast, IsEnd}, 64'd0);
        Init = 1'b0;

        check_seq("model_233168", digits_of(233168), e1);
        check_seq("model_max", digits_of(64'hFFFF_FFFF), e3);

        run_txn(32'd233168, 0, 1'b1, 1'b0);
        check_seq("t1_digits", log_q, e1);
        run_txn(32'd0, 0, 1'b1, 1'b0);
        check_seq("t2_zero", log_q, e2);
        run_txn(32'hFFFF_FFFF, 0, 1'b1, 1'b0);
        check_seq("t3_max", log_q, e3);
        run_txn(32'd233168, 1, 1'b1, 1'b0);
        check_seq("t4_stall", log_q, e1);

        // Init mid-conversion, then mid-emission, with Start left high
        log_q.delete();
        Value = 32'd233168; Start = 1'b1; DigitReady = 1'b1;
        cyc();
        repeat (9) cyc();
        Value = 32'd1000; Init = 1'b1;
        cyc();
        Init = 1'b0;
        check("t5_after_init_conv", {62'd0, DigitValid, IsEnd}, 64'd0);
        n = 0;
        while (log_q.size() < 2 && n < 200) begin cyc(); n++; end
        check("t5_emit_reached", {63'd0, (log_q.size() >= 2)}, 64'd1);
        Value = 32'd4321; Init = 1'b1;
        cyc();
        Init = 1'b0;
        check("t5_after_init_emit", {61'd0, DigitValid, DigitLast, IsEnd}, 64'd0);
        log_q.delete();
        n = 0;
        while (!IsEnd && n < 200) begin cyc(); n++; end
        check_seq("t5_recapture", log_q, e5);
        Start = 1'b0;
        cyc();

        // Start held through DONE, then one low cycle, then a new value
        run_txn(32'd777, 0, 1'b0, 1'b1);
        run_txn(32'd1000, 0, 1'b1, 1'b0);
        check_seq("t6_1000", log_q, e6);

        for (int k = 0; k < 8; k++) begin
            rv = $urandom >> $urandom_range(0, 31);
            run_txn(rv, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            check_seq("rand_digits", log_q, digits_of(longint'(rv)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
